// File: rtl/reg_memory_bank_pkg.sv
// reg_memory_bank_pkg: shared types and helpers for the register-file memory bank.
//   clr_state_e  - clear sequencer FSM states (ST_IDLE, ST_CLEAR)
//   calc_parity  - even-parity bit of a word; callers zero-extend to PAR_MAX_W
package reg_memory_bank_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

  // Widest word the parity helper accepts; zero-extension does not change parity.
  localparam int unsigned PAR_MAX_W = 64;

  function automatic logic calc_parity(input logic [PAR_MAX_W-1:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/reg_memory_bank_clr_seq.sv
// reg_memory_bank_clr_seq: IDLE/CLEAR sequencer that sweeps every word once.
// Ports:
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_clr           - start a sweep (ignored while one is running)
//   o_busy          - registered, high exactly DEPTH cycles per sweep
//   o_swp_we        - sweep write enable for the array
//   o_swp_idx       - word index written this cycle
module reg_memory_bank_clr_seq
  import reg_memory_bank_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  output logic                     o_busy,
  output logic                     o_swp_we,
  output logic [$clog2(DEPTH)-1:0] o_swp_idx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LP_LAST_IDX = AW'(DEPTH - 1);

  clr_state_e    r_state;
  logic [AW-1:0] r_clr_idx;
  logic          r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_idx <= '0;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_clr) begin
            r_state   <= ST_CLEAR;
            r_busy    <= 1'b1;
            r_clr_idx <= '0;
          end
        end
        ST_CLEAR: begin
          // i_clr is deliberately not looked at here: the sweep never restarts.
          if (r_clr_idx == LP_LAST_IDX) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + AW'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_clr_idx <= '0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_swp_we  = r_busy;
  assign o_swp_idx = r_clr_idx;

endmodule

// File: rtl/reg_memory_bank.sv
// reg_memory_bank: WIDTH x DEPTH register-file bank with one write port, one
// registered read port (1-cycle latency, write-first) and a clear sweep.
// Optional per-word even parity when REG_MEMORY_BANK_PARITY_EN is defined.
// Ports:
//   i_clk, i_rst_n              - clock, asynchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data - write request
//   i_rd_req/i_rd_addr          - read request
//   o_rd_vld/o_rd_data          - read response, one cycle after the request
//   o_addr_err                  - pulse: an accepted request used addr >= DEPTH
//   i_clr/o_busy                - start clear sweep / sweep in progress
//   o_rd_perr                   - parity mismatch on this read (with o_rd_vld)
//   i_perr_inj                  - parity build only: invert stored parity on write
module reg_memory_bank
  import reg_memory_bank_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_req,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic                     o_rd_vld,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_addr_err,
  input  logic                     i_clr,
  output logic                     o_busy,
  output logic                     o_rd_perr
`ifdef REG_MEMORY_BANK_PARITY_EN
  ,
  input  logic                     i_perr_inj
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

  logic          w_busy;
  logic          w_swp_we;
  logic [AW-1:0] w_swp_idx;

  reg_memory_bank_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_clr),
    .o_busy    (w_busy),
    .o_swp_we  (w_swp_we),
    .o_swp_idx (w_swp_idx)
  );

  logic w_acc_wr, w_acc_rd, w_wr_in, w_rd_in, w_bypass;

  assign w_acc_wr = i_wr_en & ~w_busy;
  assign w_acc_rd = i_rd_req & ~w_busy;
  assign w_wr_in  = {1'b0, i_wr_addr} < LP_DEPTH;
  assign w_rd_in  = {1'b0, i_rd_addr} < LP_DEPTH;
  assign w_bypass = w_acc_wr & w_wr_in & (i_wr_addr == i_rd_addr);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // The sweep and a host write never collide: host writes are only accepted when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= INIT_VALUE;
    end else if (w_swp_we) begin
      r_mem[w_swp_idx] <= INIT_VALUE;
    end else if (w_acc_wr && w_wr_in) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  logic [WIDTH-1:0] w_rd_word;

  always_comb begin
    w_rd_word = INIT_VALUE;
    if (w_rd_in) w_rd_word = w_bypass ? i_wr_data : r_mem[i_rd_addr];
  end

  logic             r_rd_vld;
  logic             r_addr_err;
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld   <= 1'b0;
      r_addr_err <= 1'b0;
      r_rd_data  <= INIT_VALUE;
    end else begin
      r_rd_vld   <= w_acc_rd;
      r_addr_err <= (w_acc_wr & ~w_wr_in) | (w_acc_rd & ~w_rd_in);
      if (w_acc_rd) r_rd_data <= w_rd_word;
    end
  end

  assign o_rd_vld   = r_rd_vld;
  assign o_rd_data  = r_rd_data;
  assign o_addr_err = r_addr_err;
  assign o_busy     = w_busy;

`ifdef REG_MEMORY_BANK_PARITY_EN
  localparam logic LP_INIT_PAR = calc_parity(PAR_MAX_W'(INIT_VALUE));

  logic r_par [DEPTH];
  logic w_wr_par;
  logic w_rd_perr;
  logic r_rd_perr;

  assign w_wr_par = calc_parity(PAR_MAX_W'(i_wr_data)) ^ i_perr_inj;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_par[i] <= LP_INIT_PAR;
    end else if (w_swp_we) begin
      r_par[w_swp_idx] <= LP_INIT_PAR;
    end else if (w_acc_wr && w_wr_in) begin
      r_par[i_wr_addr] <= w_wr_par;
    end
  end

  // Bypass reads compare against the parity bit being written, injection included.
  always_comb begin
    w_rd_perr = 1'b0;
    if (w_rd_in) begin
      w_rd_perr = (w_bypass ? w_wr_par : r_par[i_rd_addr]) !=
                  calc_parity(PAR_MAX_W'(w_rd_word));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rd_perr <= 1'b0;
    else          r_rd_perr <= w_acc_rd & w_rd_perr;
  end

  assign o_rd_perr = r_rd_perr;
`else
  assign o_rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_reg_memory_bank.sv
module tb_reg_memory_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 5;
  localparam int unsigned AW    = 3;
  localparam logic [7:0]  INIT  = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_req, clr;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [7:0]    wr_data;
  logic          rd_vld, addr_err, busy, rd_perr;
  logic [7:0]    rd_data;
`ifdef REG_MEMORY_BANK_PARITY_EN
  logic          perr_inj;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_mem [DEPTH];

  always #5 clk = ~clk;

  reg_memory_bank #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INIT)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rd_req   (rd_req),
    .i_rd_addr  (rd_addr),
    .o_rd_vld   (rd_vld),
    .o_rd_data  (rd_data),
    .o_addr_err (addr_err),
    .i_clr      (clr),
    .o_busy     (busy),
    .o_rd_perr  (rd_perr)
`ifdef REG_MEMORY_BANK_PARITY_EN
    ,
    .i_perr_inj (perr_inj)
`endif
  );

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL reset_rd_vld: got %b want 0", rd_vld); end
    checks++; if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rd_data !== INIT) begin failures++; $display("FAIL reset_rd_data: got %h want %h", rd_data, INIT); end
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = AW'(i);
      cyc();
      checks++; if (rd_vld !== 1'b1 || rd_data !== INIT || rd_perr !== 1'b0) begin
        failures++; $display("FAIL reset_read%0d: got vld=%b data=%h perr=%b want vld=1 data=%h perr=0", i, rd_vld, rd_data, rd_perr, INIT);
      end
    end
    rd_req = 1'b0;
    cyc();
    checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL reset_vld_pulse: got %b want 0", rd_vld); end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h3C; cyc(); exp_mem[1] = 8'h3C;
    wr_addr = 3'd2; wr_data = 8'hC3; cyc(); exp_mem[2] = 8'hC3;
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 3'd1; cyc();
    checks++; if (rd_vld !== 1'b1 || rd_data !== 8'h3C) begin failures++; $display("FAIL wr_rd_1: got vld=%b data=%h want vld=1 data=3c", rd_vld, rd_data); end
    rd_addr = 3'd2; cyc();
    checks++; if (rd_vld !== 1'b1 || rd_data !== 8'hC3) begin failures++; $display("FAIL wr_rd_2: got vld=%b data=%h want vld=1 data=c3", rd_vld, rd_data); end
    // Same-cycle write and read of one address returns the new data.
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h77; rd_addr = 3'd1; cyc(); exp_mem[1] = 8'h77;
    checks++; if (rd_vld !== 1'b1 || rd_data !== 8'h77) begin failures++; $display("FAIL write_first: got vld=%b data=%h want vld=1 data=77", rd_vld, rd_data); end
    wr_en = 1'b0; rd_req = 1'b0; cyc();
    checks++; if (rd_vld !== 1'b0 || rd_data !== 8'h77) begin failures++; $display("FAIL rd_hold: got vld=%b data=%h want vld=0 data=77", rd_vld, rd_data); end
  endtask

  task automatic test_addr_err();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h5A; cyc();
    checks++; if (addr_err !== 1'b1 || rd_vld !== 1'b0) begin failures++; $display("FAIL oor_write: got err=%b vld=%b want err=1 vld=0", addr_err, rd_vld); end
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 3'd6; cyc();
    checks++; if (addr_err !== 1'b1 || rd_vld !== 1'b1 || rd_data !== INIT) begin
      failures++; $display("FAIL oor_read: got err=%b vld=%b data=%h want err=1 vld=1 data=%h", addr_err, rd_vld, rd_data, INIT);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i); cyc();
      checks++; if (rd_data !== exp_mem[i] || addr_err !== 1'b0) begin
        failures++; $display("FAIL oor_unchanged%0d: got data=%h err=%b want data=%h err=0", i, rd_data, addr_err, exp_mem[i]);
      end
    end
    rd_req = 1'b0; cyc();
  endtask

  task automatic test_clear();
    int busy_cnt;
    bit done;
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_addr = AW'(i); wr_data = 8'h10 + 8'(i); cyc(); exp_mem[i] = 8'h10 + 8'(i);
    end
    wr_en = 1'b0;
    // Read in the clr cycle is still serviced.
    clr = 1'b1; rd_req = 1'b1; rd_addr = 3'd3; cyc();
    checks++; if (busy !== 1'b1 || rd_vld !== 1'b1 || rd_data !== exp_mem[3]) begin
      failures++; $display("FAIL clr_start: got busy=%b vld=%b data=%h want busy=1 vld=1 data=%h", busy, rd_vld, rd_data, exp_mem[3]);
    end
    clr = 1'b0;
    // A write attempted during the sweep must be dropped.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; rd_addr = 3'd0;
    busy_cnt = 1; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      clr = (k == 1);
      cyc();
      if (busy) begin
        busy_cnt++;
        checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL clr_drop_rd: got vld=%b want 0", rd_vld); end
      end else begin
        done = 1'b1;
      end
    end
    clr = 1'b0;
    checks++; if (!done) begin failures++; $display("FAIL clr_timeout: busy still %b after 20 cycles, want 0", busy); end
    checks++; if (busy_cnt != DEPTH) begin failures++; $display("FAIL clr_busy_len: got %0d want %0d", busy_cnt, DEPTH); end
    checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL clr_last_drop: got vld=%b want 0", rd_vld); end
    wr_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = INIT;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i); cyc();
      checks++; if (rd_vld !== 1'b1 || rd_data !== INIT) begin
        failures++; $display("FAIL clr_word%0d: got vld=%b data=%h want vld=1 data=%h", i, rd_vld, rd_data, INIT);
      end
    end
    rd_req = 1'b0; cyc();
  endtask

  task automatic test_reset_mid_sweep();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h99; cyc();
    wr_en = 1'b0; clr = 1'b1; cyc();
    clr = 1'b0; cyc(); cyc();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_sweep_busy: got %b want 1", busy); end
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || rd_vld !== 1'b0 || rd_data !== INIT) begin
      failures++; $display("FAIL async_reset: got busy=%b vld=%b data=%h want busy=0 vld=0 data=%h", busy, rd_vld, rd_data, INIT);
    end
    @(negedge clk); rst_n = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = AW'(i); cyc();
      checks++; if (rd_vld !== 1'b1 || rd_data !== INIT) begin
        failures++; $display("FAIL rst_word%0d: got vld=%b data=%h want vld=1 data=%h", i, rd_vld, rd_data, INIT);
      end
    end
    rd_req = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h42; cyc();
    wr_en = 1'b0; rd_req = 1'b1; rd_addr = 3'd3; cyc();
    checks++; if (rd_vld !== 1'b1 || rd_data !== 8'h42) begin failures++; $display("FAIL post_rst_rw: got vld=%b data=%h want vld=1 data=42", rd_vld, rd_data); end
    rd_req = 1'b0; cyc();
  endtask

`ifdef REG_MEMORY_BANK_PARITY_EN
  task automatic test_parity();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h01; perr_inj = 1'b1; cyc();
    wr_en = 1'b0; perr_inj = 1'b0; rd_req = 1'b1; rd_addr = 3'd0; cyc();
    checks++; if (rd_vld !== 1'b1 || rd_perr !== 1'b1 || rd_data !== 8'h01) begin
      failures++; $display("FAIL perr_inj: got vld=%b perr=%b data=%h want vld=1 perr=1 data=01", rd_vld, rd_perr, rd_data);
    end
    rd_req = 1'b0; wr_en = 1'b1; cyc();
    wr_en = 1'b0; rd_req = 1'b1; cyc();
    checks++; if (rd_vld !== 1'b1 || rd_perr !== 1'b0) begin
      failures++; $display("FAIL perr_clean: got vld=%b perr=%b want vld=1 perr=0", rd_vld, rd_perr);
    end
    rd_req = 1'b0; cyc();
  endtask
`endif

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_req = 1'b0; clr = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
`ifdef REG_MEMORY_BANK_PARITY_EN
    perr_inj = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = INIT;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_addr_err();
    test_clear();
    test_reset_mid_sweep();
`ifdef REG_MEMORY_BANK_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
